// File: rtl/gmii_tx_sched.sv
// gmii_tx_sched
//   Frame-level scheduler that shares one GMII transmit path between two
//   first-word-fall-through byte FIFOs (requester 0: loopback, requester 1:
//   host inject). At frame boundaries it picks a requester round-robin,
//   emits PRE_LEN x 0x55 plus SFD 0xD5, streams the granted frame until its
//   last-byte flag, then holds the line idle for IFG_CYCLES cycles. If the
//   granted FIFO runs dry mid-frame, transmission stops, underrun pulses, and
//   the rest of that frame is popped and discarded.
//
// Ports
//   gmii_gtx_clk_i         transmit clock (sole clock)
//   sys_rst_n_i            asynchronous active-low reset
//   rqN_rdy_i              requester N holds at least one complete frame
//   rqN_empty_i            requester N FIFO empty
//   rqN_data_i[8:0]        [7:0] byte, [8] last byte of frame
//   rqN_rd_o               pop strobe to requester N (combinational)
//   gmii_en_o              registered transmit enable
//   gmii_dout_o[7:0]       registered transmit byte
//   grant_o[1:0]           one-hot owner of the frame on the line, 00 when idle
//   underrun_o             one-cycle pulse when the granted FIFO ran dry
//
// Optional feature (macro GMII_TX_SCHED_STATS_EN)
//   frm_cnt0_o/frm_cnt1_o  [31:0] frames completed per requester (saturating)
//   urun_cnt_o             [15:0] underrun events (saturating)
module gmii_tx_sched #(
  parameter int IFG_CYCLES = 12,
  parameter int PRE_LEN    = 7
) (
  input  logic       gmii_gtx_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       rq0_rdy_i,
  input  logic       rq0_empty_i,
  input  logic [8:0] rq0_data_i,
  output logic       rq0_rd_o,
  input  logic       rq1_rdy_i,
  input  logic       rq1_empty_i,
  input  logic [8:0] rq1_data_i,
  output logic       rq1_rd_o,
  output logic       gmii_en_o,
  output logic [7:0] gmii_dout_o,
  output logic [1:0] grant_o,
  output logic       underrun_o
`ifdef GMII_TX_SCHED_STATS_EN
  ,
  output logic [31:0] frm_cnt0_o,
  output logic [31:0] frm_cnt1_o,
  output logic [15:0] urun_cnt_o
`endif
);

  localparam int CNT_MAX = (PRE_LEN > IFG_CYCLES) ? PRE_LEN : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_DRAIN, S_IFG} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             own_q, own_d;    // index of the granted requester
  logic             rr_q, rr_d;      // requester preferred when both are ready
  logic             en_q, en_d;
  logic [7:0]       dout_q, dout_d;
  logic [1:0]       grant_q, grant_d;
  logic             urun_q, urun_d;

  logic             sel_empty;
  logic [8:0]       sel_data;
  logic             pop;
  logic [1:0]       own_onehot;

  assign sel_empty  = own_q ? rq1_empty_i : rq0_empty_i;
  assign sel_data   = own_q ? rq1_data_i  : rq0_data_i;
  assign own_onehot = own_q ? 2'b10 : 2'b01;

  // Pops happen only in DATA/DRAIN and only towards the owner.
  assign pop      = ((state_q == S_DATA) || (state_q == S_DRAIN)) && !sel_empty;
  assign rq0_rd_o = pop && !own_q;
  assign rq1_rd_o = pop &&  own_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    rr_d    = rr_q;
    en_d    = 1'b0;
    dout_d  = 8'h00;
    grant_d = 2'b00;
    urun_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rq0_rdy_i || rq1_rdy_i) begin
          own_d   = (rq0_rdy_i && rq1_rdy_i) ? rr_q : rq1_rdy_i;
          state_d = S_PRE;
          cnt_d   = '0;
        end
      end
      S_PRE: begin
        en_d    = 1'b1;
        grant_d = own_onehot;
        if (cnt_q == CNT_W'(PRE_LEN)) begin
          dout_d  = 8'hD5;
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          dout_d = 8'h55;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        grant_d = own_onehot;
        if (!sel_empty) begin
          en_d   = 1'b1;
          dout_d = sel_data[7:0];
          if (sel_data[8]) begin
            state_d = S_IFG;
            cnt_d   = '0;
            rr_d    = ~own_q;
          end
        end else begin
          urun_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Line stays quiet; the remainder of the broken frame is discarded.
        grant_d = own_onehot;
        if (pop && sel_data[8]) begin
          state_d = S_IFG;
          cnt_d   = '0;
        end
      end
      S_IFG: begin
        if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_gtx_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      own_q   <= 1'b0;
      rr_q    <= 1'b0;
      en_q    <= 1'b0;
      dout_q  <= 8'h00;
      grant_q <= 2'b00;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      en_q    <= en_d;
      dout_q  <= dout_d;
      grant_q <= grant_d;
      urun_q  <= urun_d;
    end
  end

  assign gmii_en_o   = en_q;
  assign gmii_dout_o = dout_q;
  assign grant_o     = grant_q;
  assign underrun_o  = urun_q;

`ifdef GMII_TX_SCHED_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0] frm0_q, frm1_q;
  logic [15:0] urc_q;
  logic        frm_done;

  assign frm_done = (state_q == S_DATA) && pop && sel_data[8];

  always_ff @(posedge gmii_gtx_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      frm0_q <= '0;
      frm1_q <= '0;
      urc_q  <= '0;
    end else begin
      if (frm_done && !own_q) frm0_q <= sat_inc32(frm0_q);
      if (frm_done &&  own_q) frm1_q <= sat_inc32(frm1_q);
      if (urun_d)             urc_q  <= sat_inc16(urc_q);
    end
  end

  assign frm_cnt0_o = frm0_q;
  assign frm_cnt1_o = frm1_q;
  assign urun_cnt_o = urc_q;
`endif

endmodule

// File: tb/tb_gmii_tx_sched.sv
module tb_gmii_tx_sched;

  localparam int IFG = 12;
  localparam int PRE = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rq0_rdy, rq0_empty, rq0_rd;
  logic       rq1_rdy, rq1_empty, rq1_rd;
  logic [8:0] rq0_data, rq1_data;
  logic       gmii_en, underrun;
  logic [7:0] gmii_dout;
  logic [1:0] grant;
`ifdef GMII_TX_SCHED_STATS_EN
  logic [31:0] frm_cnt0, frm_cnt1;
  logic [15:0] urun_cnt;
`endif

  gmii_tx_sched #(.IFG_CYCLES(IFG), .PRE_LEN(PRE)) dut (
    .gmii_gtx_clk_i(clk),
    .sys_rst_n_i   (rst_n),
    .rq0_rdy_i     (rq0_rdy),
    .rq0_empty_i   (rq0_empty),
    .rq0_data_i    (rq0_data),
    .rq0_rd_o      (rq0_rd),
    .rq1_rdy_i     (rq1_rdy),
    .rq1_empty_i   (rq1_empty),
    .rq1_data_i    (rq1_data),
    .rq1_rd_o      (rq1_rd),
    .gmii_en_o     (gmii_en),
    .gmii_dout_o   (gmii_dout),
    .grant_o       (grant),
    .underrun_o    (underrun)
`ifdef GMII_TX_SCHED_STATS_EN
    ,
    .frm_cnt0_o    (frm_cnt0),
    .frm_cnt1_o    (frm_cnt1),
    .urun_cnt_o    (urun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Requester FIFO models
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int   frm0 = 0, frm1 = 0;
  logic force0 = 1'b0;
  logic pend0 = 1'b0, pend1 = 1'b0;
  int   pops0 = 0, pops1 = 0, bad_pop = 0, both_rd = 0;
  int   checks = 0, failures = 0;

  task automatic refresh();
    rq0_empty = (q0.size() == 0);
    rq0_data  = rq0_empty ? 9'h000 : q0[0];
    rq0_rdy   = (frm0 > 0) || force0;
    rq1_empty = (q1.size() == 0);
    rq1_data  = rq1_empty ? 9'h000 : q1[0];
    rq1_rdy   = (frm1 > 0);
  endtask

  always @(posedge clk) begin
    pend0 <= rq0_rd;
    pend1 <= rq1_rd;
    if (rq0_rd && rq1_rd) both_rd <= both_rd + 1;
  end

  always @(negedge clk) begin
    if (pend0) begin
      if (q0.size() == 0) bad_pop++;
      else begin
        if (q0[0][8]) frm0--;
        void'(q0.pop_front());
        pops0++;
      end
    end
    if (pend1) begin
      if (q1.size() == 0) bad_pop++;
      else begin
        if (q1[0][8]) frm1--;
        void'(q1.pop_front());
        pops1++;
      end
    end
    refresh();
  end

  task automatic push_frame(input int req, input int len, input logic [63:0] bytes,
                            input bit term);
    logic [8:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(term && (i == len - 1)), bytes[i*8 +: 8]};
      if (req == 0) q0.push_back(w);
      else          q1.push_back(w);
    end
    if (term && req == 0) frm0++;
    if (term && req == 1) frm1++;
    refresh();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Waits for gmii_en to rise, then checks preamble, SFD and payload cycle by
  // cycle. idle returns the number of en-low samples seen before the frame.
  task automatic expect_frame(input int req, input int len, input logic [63:0] bytes,
                              output int idle);
    logic [7:0] exp_b;
    logic [1:0] exp_g;
    idle = 0;
    @(negedge clk);
    while (gmii_en !== 1'b1 && idle < 300) begin
      idle++;
      @(negedge clk);
    end
    if (gmii_en !== 1'b1) begin
      chk($sformatf("frame_r%0d_start_timeout", req), 32'(gmii_en), 32'd1);
      return;
    end
    exp_g = (req == 1) ? 2'b10 : 2'b01;
    for (int k = 0; k < PRE + 1 + len; k++) begin
      if (k > 0) @(negedge clk);
      if (k < PRE)       exp_b = 8'h55;
      else if (k == PRE) exp_b = 8'hD5;
      else               exp_b = bytes[(k - PRE - 1)*8 +: 8];
      chk($sformatf("frame_r%0d_cyc%0d{en,dout,grant}", req, k),
          {21'b0, gmii_en, gmii_dout, grant}, {21'b0, 1'b1, exp_b, exp_g});
    end
  endtask

  typedef struct {
    int          req;
    int          len;
    logic [63:0] bytes;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int idle, bad, urun_seen;

    vecs[0] = '{0, 3, 64'h0000_0000_00A3_A2A1};
    vecs[1] = '{1, 2, 64'h0000_0000_0000_B2B1};
    vecs[2] = '{0, 1, 64'h0000_0000_0000_00C1};
    vecs[3] = '{1, 4, 64'h0000_0000_D4D3_D2D1};

    rst_n = 1'b0;
    refresh();
    @(negedge clk);

    // Reset held with requester 0 ready
    push_frame(0, 4, 64'h4433_2211, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_en", 32'(gmii_en), 32'd0);
      chk("reset_grant", 32'(grant), 32'd0);
      chk("reset_rd", 32'({pend0, pend1}), 32'd0);
    end
    rst_n = 1'b1;

    // 4-byte frame on requester 0
    expect_frame(0, 4, 64'h4433_2211, idle);
    chk("reset_release_start_le2", 32'(idle <= 2), 32'd1);
    bad = 0;
    for (int i = 0; i < IFG + 1; i++) begin
      @(negedge clk);
      if (gmii_en !== 1'b0 || grant !== 2'b00 || underrun !== 1'b0) bad++;
    end
    chk("frame1_gap_quiet", 32'(bad), 32'd0);
    chk("frame1_pops", 32'(pops0), 32'd4);

    // 1-byte frame on requester 1
    repeat (5) @(negedge clk);
    pops0 = 0;
    pops1 = 0;
    push_frame(1, 1, 64'hAB, 1'b1);
    expect_frame(1, 1, 64'hAB, idle);
    repeat (3) @(negedge clk);
    chk("one_byte_rd1_cycles", 32'(pops1), 32'd1);
    chk("one_byte_rd0_none", 32'(pops0), 32'd0);

    // Both requesters ready with two frames each: strict alternation
    repeat (20) @(negedge clk);
    pops0 = 0;
    pops1 = 0;
    for (int i = 0; i < 4; i++) push_frame(vecs[i].req, vecs[i].len, vecs[i].bytes, 1'b1);
    for (int i = 0; i < 4; i++) begin
      expect_frame(vecs[i].req, vecs[i].len, vecs[i].bytes, idle);
      if (i > 0) chk($sformatf("arb_gap_%0d", i), 32'(idle), 32'(IFG + 1));
    end
    repeat (3) @(negedge clk);
    chk("arb_pops0", 32'(pops0), 32'd4);
    chk("arb_pops1", 32'(pops1), 32'd6);

    // Underrun on requester 0 after 2 bytes; requester 1 waiting
    repeat (20) @(negedge clk);
    pops0 = 0;
    pops1 = 0;
    force0 = 1'b1;
    push_frame(0, 2, 64'h6261, 1'b0);
    push_frame(1, 2, 64'h7271, 1'b1);
    expect_frame(0, 2, 64'h6261, idle);
    @(negedge clk);
    chk("urun_en_drop", 32'(gmii_en), 32'd0);
    chk("urun_pulse", 32'(underrun), 32'd1);
    @(negedge clk);
    chk("urun_single", 32'(underrun), 32'd0);
    bad = 0;
    urun_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gmii_en !== 1'b0) bad++;
      if (underrun !== 1'b0) urun_seen++;
    end
    chk("drain_en_quiet", 32'(bad), 32'd0);
    chk("drain_no_repulse", 32'(urun_seen), 32'd0);
    force0 = 1'b0;
    push_frame(0, 3, 64'h65_6463, 1'b1);
    expect_frame(1, 2, 64'h7271, idle);
    chk("urun_ifg_ge", 32'(idle >= IFG + 1), 32'd1);
    repeat (3) @(negedge clk);
    chk("urun_pops0", 32'(pops0), 32'd5);
    chk("urun_pops1", 32'(pops1), 32'd2);
    chk("urun_q0_empty", 32'(q0.size()), 32'd0);

`ifdef GMII_TX_SCHED_STATS_EN
    chk("stats_frm0", frm_cnt0, 32'd3);
    chk("stats_frm1", frm_cnt1, 32'd4);
    chk("stats_urun", 32'(urun_cnt), 32'd1);
`endif

    // Asynchronous reset in the middle of a preamble
    repeat (20) @(negedge clk);
    push_frame(0, 2, 64'hE2E1, 1'b1);
    idle = 0;
    while (gmii_en !== 1'b1 && idle < 100) begin
      @(negedge clk);
      idle++;
    end
    chk("mfr_started", 32'(gmii_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mfr_async_en", 32'(gmii_en), 32'd0);
    chk("mfr_async_grant", 32'(grant), 32'd0);
    chk("mfr_async_dout", 32'(gmii_dout), 32'd0);
    chk("mfr_fifo_untouched", 32'(q0.size()), 32'd2);
    q0.delete();
    frm0 = 0;
    refresh();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (gmii_en !== 1'b0 || grant !== 2'b00) bad++;
    end
    chk("mfr_after_quiet", 32'(bad), 32'd0);

    chk("never_both_rd", 32'(both_rd), 32'd0);
    chk("never_pop_empty", 32'(bad_pop), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
